alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that performs unsigned 64-bit multiply (low half) and unsigned restoring divide.
- Drives the shared 64-bit ALU through its control and operand inputs, one add or subtract per cycle.
- Sits in the execute stage beside the ALU.
- Pipeline control stalls on ready_o and collects the result on done_o.

---
 rtl/alu_muldiv_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Multi-cycle sequencer for unsigned XLEN-bit multiply (low half of the
// product) and unsigned restoring divide. It borrows the shared execute-stage
// ALU, issuing one add (multiply) or one subtract (divide) per cycle. While
// the sequencer is in MUL or DIV it owns the ALU exclusively.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset, aborts any operation
//   start_i        request, accepted only while ready_o=1
//   op_i           0 = multiply, 1 = divide (sampled on accept)
//   a_i, b_i       multiplicand/dividend, multiplier/divisor (sampled on accept)
//   ready_o        high only in IDLE
//   done_o         one-cycle pulse; result_o/rem_o/div_by_zero_o valid
//   result_o       product low half or quotient (held until the next result)
//   rem_o          remainder for divide, 0 for multiply
//   div_by_zero_o  divide with b=0; cleared on the next accept
//   alu_ctrl_o     4'b0010 add, 4'b0110 sub, 4'b0000 idle
//   alu_op1_o      ALU operand 1
//   alu_op2_o      ALU operand 2
//   alu_result_i   combinational ALU result for the current operands
module alu_muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] rem_o,
  output logic            div_by_zero_o,
  output logic [3:0]      alu_ctrl_o,
  output logic [XLEN-1:0] alu_op1_o,
  output logic [XLEN-1:0] alu_op2_o,
  input  logic [XLEN-1:0] alu_result_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0]       ALU_IDLE = 4'b0000;
  localparam logic [3:0]       ALU_ADD  = 4'b0010;
  localparam logic [3:0]       ALU_SUB  = 4'b0110;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc: running product (MUL) or partial remainder (DIV)
  logic [XLEN-1:0]   acc_q, acc_d;
  // opa: shifting multiplicand (MUL) or dividend that fills with quotient bits (DIV)
  logic [XLEN-1:0]   opa_q, opa_d;
  // opb: shifting multiplier (MUL) or constant divisor (DIV)
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic [XLEN-1:0]   rs;
  logic              q_bit;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;

  // Dropping rem[XLEN-1] from the shifted remainder is safe: the partial
  // remainder only has its top bit set when the divisor does too, and then
  // a quotient 1 can only occur on the final step, where rs still fits.
  assign rs       = {acc_q[XLEN-2:0], opa_q[XLEN-1]};
  assign q_bit    = (rs >= opb_q);
  assign rem_next = q_bit ? alu_result_i : rs;
  assign quo_next = {opa_q[XLEN-2:0], q_bit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    result_d   = result_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    alu_ctrl_o = ALU_IDLE;
    alu_op1_o  = '0;
    alu_op2_o  = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d = '0;
          acc_d = '0;
          opa_d = a_i;
          opb_d = b_i;
          dbz_d = 1'b0;
          if (!op_i) begin
            state_d = S_MUL;
          end else if (b_i != '0) begin
            state_d = S_DIV;
          end else begin
            // Divide by zero short-circuits straight to DONE
            state_d  = S_DONE;
            result_d = '1;
            rem_d    = a_i;
            dbz_d    = 1'b1;
          end
        end
      end

      S_MUL: begin
        alu_ctrl_o = ALU_ADD;
        alu_op1_o  = acc_q;
        alu_op2_o  = opb_q[0] ? opa_q : '0;
        acc_d      = alu_result_i;
        opa_d      = opa_q << 1;
        opb_d      = opb_q >> 1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = alu_result_i;
          rem_d    = '0;
        end
      end

      S_DIV: begin
        alu_ctrl_o = ALU_SUB;
        alu_op1_o  = rs;
        alu_op2_o  = opb_q;
        acc_d      = rem_next;
        opa_d      = quo_next;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = quo_next;
          rem_d    = rem_next;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end

  assign ready_o       = (state_q == S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign result_o      = result_q;
  assign rem_o         = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq: a behavioural ALU closes the loop, and each
// scenario task drives stimulus and compares against plain-arithmetic
// expectations (a*b mod 2^64, a/b, a%b).
module tb_alu_muldiv_seq;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] rem;
  logic            dbz;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [XLEN-1:0] alu_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared ALU stand-in
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_res = alu_op1 + alu_op2;
      4'b0110: alu_res = alu_op1 - alu_op2;
      default: alu_res = '0;
    endcase
  end

  alu_muldiv_seq #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .ready_o       (ready),
    .done_o        (done),
    .result_o      (result),
    .rem_o         (rem),
    .div_by_zero_o (dbz),
    .alu_ctrl_o    (alu_ctrl),
    .alu_op1_o     (alu_op1),
    .alu_op2_o     (alu_op2),
    .alu_result_i  (alu_res)
  );

  // Issue one request at the current negedge (DUT must be idle) and wait for
  // done_o. cyc is the number of cycles from accept to done (bounded at 200).
  // bad counts busy cycles where alu_ctrl or ready_o was not as required.
  task automatic run_op(input logic [XLEN-1:0] ta, input logic [XLEN-1:0] tb_v,
                        input logic top, input logic hold_start,
                        output int cyc, output int bad);
    logic [3:0] exp_ctrl;
    exp_ctrl = top ? 4'b0110 : 4'b0010;
    cyc = 0;
    bad = 0;
    a = ta; b = tb_v; op = top; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    if (hold_start) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = ~top;
    end else begin
      start = 1'b0;
    end
    while (!done && cyc < 200) begin
      if (alu_ctrl !== exp_ctrl || ready !== 1'b0) bad++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (result !== 64'd0 || rem !== 64'd0) begin errors++; $display("FAIL reset_result got=%0h/%0h exp=0/0", result, rem); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%0b exp=0", dbz); end
    checks++; if (alu_ctrl !== 4'b0000 || alu_op1 !== 64'd0 || alu_op2 !== 64'd0) begin
      errors++; $display("FAIL reset_alu got=%0h/%0h/%0h exp=0/0/0", alu_ctrl, alu_op1, alu_op2); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    int cyc, bad;
    run_op(64'd6, 64'd7, 1'b0, 1'b0, cyc, bad);
    checks++; if (cyc !== 65) begin errors++; $display("FAIL mul_latency got=%0d exp=65", cyc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mul_busy_ctrl bad_cycles=%0d exp=0", bad); end
    checks++; if (result !== 64'd42) begin errors++; $display("FAIL mul_result got=%0d exp=42", result); end
    checks++; if (rem !== 64'd0 || dbz !== 1'b0) begin errors++; $display("FAIL mul_rem_dbz got=%0d/%0b exp=0/0", rem, dbz); end
    checks++; if (alu_ctrl !== 4'b0000) begin errors++; $display("FAIL done_alu_idle got=%0h exp=0", alu_ctrl); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL mul_pulse got done=%0b ready=%0b exp 0/1", done, ready); end
    checks++; if (result !== 64'd42) begin errors++; $display("FAIL mul_hold got=%0d exp=42", result); end
  endtask

  task automatic test_mul_overflow();
    int cyc, bad;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, cyc, bad);
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_ctrl bad_cycles=%0d exp=0", bad); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL ovf_result got=%0h exp=fffffffffffffffe", result); end
    @(negedge clk);
  endtask

  task automatic test_div();
    int cyc, bad;
    run_op(64'd100, 64'd7, 1'b1, 1'b0, cyc, bad);
    checks++; if (cyc !== 65) begin errors++; $display("FAIL div_latency got=%0d exp=65", cyc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL div_ctrl bad_cycles=%0d exp=0", bad); end
    checks++; if (result !== 64'd14 || rem !== 64'd2) begin errors++; $display("FAIL div_result got=%0d r%0d exp=14 r2", result, rem); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL div_dbz got=%0b exp=0", dbz); end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    int cyc, bad;
    run_op(64'd123, 64'd0, 1'b1, 1'b0, cyc, bad);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL dbz_latency got=%0d exp=1", cyc); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF || rem !== 64'd123) begin
      errors++; $display("FAIL dbz_result got=%0h r%0d exp=ffffffffffffffff r123", result, rem); end
    checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%0b exp=1", dbz); end
    @(negedge clk);
    checks++; if (dbz !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL dbz_hold got dbz=%0b done=%0b exp 1/0", dbz, done); end
    run_op(64'd9, 64'd9, 1'b0, 1'b0, cyc, bad);
    checks++; if (dbz !== 1'b0 || result !== 64'd81) begin errors++; $display("FAIL dbz_clear got dbz=%0b res=%0d exp 0/81", dbz, result); end
    @(negedge clk);
  endtask

  task automatic test_start_held();
    int cyc, bad;
    run_op(64'd1234, 64'd5678, 1'b0, 1'b1, cyc, bad);
    checks++; if (cyc !== 65 || bad !== 0) begin errors++; $display("FAIL held_start got cyc=%0d bad=%0d exp 65/0", cyc, bad); end
    checks++; if (result !== 64'd7006652) begin errors++; $display("FAIL held_result got=%0d exp=7006652", result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    a = 64'd1000; b = 64'd3; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL midrst_state got ready=%0b done=%0b exp 1/0", ready, done); end
    checks++; if (result !== 64'd0 || rem !== 64'd0) begin errors++; $display("FAIL midrst_result got=%0d/%0d exp=0/0", result, rem); end
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back();
    int cyc, bad;
    run_op(64'd1000, 64'd33, 1'b1, 1'b0, cyc, bad);
    checks++; if (result !== 64'd30 || rem !== 64'd10) begin errors++; $display("FAIL b2b_div got=%0d r%0d exp=30 r10", result, rem); end
    @(negedge clk);
    run_op(64'd11, 64'd13, 1'b0, 1'b0, cyc, bad);
    checks++; if (cyc !== 65 || result !== 64'd143) begin errors++; $display("FAIL b2b_mul got cyc=%0d res=%0d exp 65/143", cyc, result); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc, bad;
    logic [XLEN-1:0] ra, rb, er, erm;
    logic rop;
    for (int i = 0; i < 700; i++) begin
      rop = i[0];
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: rb = rb & 64'hFFFF;
        1: rb = rb & 64'hFFFF_FFFF;
        default: ;
      endcase
      if (rb == '0) rb = 64'd1;
      er  = rop ? ra / rb : ra * rb;
      erm = rop ? ra % rb : 64'd0;
      run_op(ra, rb, rop, 1'b0, cyc, bad);
      checks++; if (cyc !== 65 || bad !== 0) begin errors++; $display("FAIL rand_timing op=%0b got cyc=%0d bad=%0d exp 65/0", rop, cyc, bad); end
      checks++; if (result !== er || rem !== erm) begin
        errors++; $display("FAIL rand_result op=%0b a=%0h b=%0h got=%0h r%0h exp=%0h r%0h", rop, ra, rb, result, rem, er, erm); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand_pulse_width got=%0b exp=0", done); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_overflow();
    test_div();
    test_div_by_zero();
    test_start_held();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
